// File: rtl/ysyx_23060124_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: state encodings,
// reset PC, bus response codes and small PC helpers.
package ysyx_23060124_ifu_pkg;

    localparam int          IFU_ADDR_W = 32;
    localparam logic [31:0] IFU_RST_PC = 32'h8000_0000;
    localparam logic [1:0]  RRESP_OKAY = 2'b00;
    localparam logic [31:0] INS_NONE   = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_AR   = 2'b00,
        S_R    = 2'b01,
        S_OUT  = 2'b10,
        S_WAIT = 2'b11
    } ifu_state_e;

    // Instructions are word aligned; any low-bit set means the fetch cannot be issued.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return (pc_lo != 2'b00);
    endfunction

    function automatic logic resp_fault(input logic [1:0] resp);
        return (resp != RRESP_OKAY);
    endfunction

endpackage

// File: rtl/ysyx_23060124_ifu_if.sv
// Fetch-side connection bundle: AR/R read bus toward memory plus the
// decoder handshake and next-PC input from write-back.
interface ysyx_23060124_ifu_if
    import ysyx_23060124_ifu_pkg::*;
#(
    parameter int ADDR_W = IFU_ADDR_W
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [31:0]       ins;
    logic [ADDR_W-1:0] pc;
    logic              fetch_err;
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] npc;
    logic              npc_valid;

    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid,
        output ins, pc, fetch_err, valid,
        input  ready, npc, npc_valid
    );

    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid,
        input  ins, pc, fetch_err, valid,
        output ready, npc, npc_valid
    );
endinterface

// File: rtl/ysyx_23060124_ifu.sv
// Instruction fetch unit for a multicycle core: one AR/R read per instruction,
// result handed to the decoder, then idle until write-back supplies the next PC.
module ysyx_23060124_ifu
    import ysyx_23060124_ifu_pkg::*;
#(
    parameter int                ADDR_W = IFU_ADDR_W,
    parameter logic [ADDR_W-1:0] RST_PC = IFU_RST_PC
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    ysyx_23060124_ifu_if.master  bus
);

    ifu_state_e        state_r;
    ifu_state_e        state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [31:0]       ins_r;
    logic [31:0]       ins_nxt_s;
    logic              err_r;
    logic              err_nxt_s;
    logic              arvalid_r;
    logic              rready_r;
    logic              valid_r;
    logic              take_npc_s;

    // Next-PC is accepted while idle, or in the same cycle the decoder takes the word.
    always_comb begin
        take_npc_s = 1'b0;
        if (bus.npc_valid && ((state_r == S_WAIT) || ((state_r == S_OUT) && bus.ready))) begin
            take_npc_s = 1'b1;
        end else begin
            take_npc_s = 1'b0;
        end
    end

    // Next-state and datapath update for the fetch sequence.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        ins_nxt_s   = ins_r;
        err_nxt_s   = err_r;
        case (state_r)
            S_AR: begin
                if (bus.arready) begin
                    state_nxt_s = S_R;
                end else begin
                    state_nxt_s = S_AR;
                end
            end
            S_R: begin
                if (bus.rvalid) begin
                    // A faulted response must not leak garbage into the decoder.
                    ins_nxt_s   = resp_fault(bus.rresp) ? INS_NONE : bus.rdata;
                    err_nxt_s   = resp_fault(bus.rresp);
                    state_nxt_s = S_OUT;
                end else begin
                    state_nxt_s = S_R;
                end
            end
            S_OUT: begin
                if (bus.ready) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_OUT;
                end
            end
            S_WAIT: begin
                state_nxt_s = S_WAIT;
            end
            default: begin
                state_nxt_s = S_AR;
            end
        endcase

        if (take_npc_s) begin
            pc_nxt_s = bus.npc;
            if (pc_misaligned(bus.npc[1:0])) begin
                // Misaligned target: report straight to the decoder without touching the bus.
                ins_nxt_s   = INS_NONE;
                err_nxt_s   = 1'b1;
                state_nxt_s = S_OUT;
            end else begin
                state_nxt_s = S_AR;
            end
        end else begin
            pc_nxt_s = pc_nxt_s;
        end
    end

    // State, datapath and Moore-output registers; outputs track the next state so
    // they change on the same edge as the state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= S_AR;
            pc_r      <= RST_PC;
            ins_r     <= INS_NONE;
            err_r     <= 1'b0;
            arvalid_r <= 1'b1;
            rready_r  <= 1'b0;
            valid_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            ins_r     <= ins_nxt_s;
            err_r     <= err_nxt_s;
            arvalid_r <= (state_nxt_s == S_AR);
            rready_r  <= (state_nxt_s == S_R);
            valid_r   <= (state_nxt_s == S_OUT);
        end
    end

    assign bus.araddr    = pc_r;
    assign bus.arvalid   = arvalid_r;
    assign bus.rready    = rready_r;
    assign bus.ins       = ins_r;
    assign bus.pc        = pc_r;
    assign bus.fetch_err = err_r;
    assign bus.valid     = valid_r;

endmodule

// File: tb/tb_ysyx_23060124_ifu.sv
// Directed bench for the fetch unit: a configurable-latency read slave plus a
// scoreboard of expected decoder-side results.
module tb_ysyx_23060124_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    exp_t sb[$];

    // slave configuration
    int          ar_stall = 0;
    int          r_stall = 0;
    logic [31:0] rdata_cfg = 32'h0;
    logic [1:0]  rresp_cfg = 2'b00;
    logic        late_rvalid = 1'b0;

    // slave state
    int          ar_wait_cnt;
    int          r_cnt;
    logic        r_pending;
    int          ar_count = 0;
    logic [31:0] last_araddr = 32'h0;

    ysyx_23060124_ifu_if #(.ADDR_W(32)) bus ();

    ysyx_23060124_ifu #(.ADDR_W(32), .RST_PC(RST_PC)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.arready = bus.arvalid && (ar_wait_cnt >= ar_stall);
    assign bus.rvalid  = (r_pending && (r_cnt >= r_stall)) || late_rvalid;
    assign bus.rdata   = late_rvalid ? 32'hBAD0_BAD0 : rdata_cfg;
    assign bus.rresp   = rresp_cfg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_wait_cnt <= 0;
            r_cnt       <= 0;
            r_pending   <= 1'b0;
        end else begin
            if (bus.arvalid && bus.arready) begin
                ar_wait_cnt <= 0;
                r_pending   <= 1'b1;
                r_cnt       <= 0;
                ar_count    <= ar_count + 1;
                last_araddr <= bus.araddr;
            end else if (bus.arvalid) begin
                ar_wait_cnt <= ar_wait_cnt + 1;
            end
            if (bus.rvalid && bus.rready) begin
                r_pending <= 1'b0;
            end else if (r_pending) begin
                r_cnt <= r_cnt + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, input logic [31:0] exp_addr, output int cyc);
        cyc = 0;
        while (!bus.valid && cyc < budget) begin
            if (bus.arvalid) check("araddr_hold", bus.araddr, exp_addr);
            step();
            cyc++;
        end
        if (!bus.valid) check("valid_timeout", 32'(bus.valid), 32'd1);
    endtask

    task automatic pop_compare(input string tag, output exp_t e);
        e = '0;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"}, 32'(bus.valid), 32'd1);
            check({tag, "_ins"}, bus.ins, e.ins);
            check({tag, "_pc"}, bus.pc, e.pc);
            check({tag, "_err"}, 32'(bus.fetch_err), 32'(e.err));
        end
    endtask

    task automatic accept_and_npc(input logic [31:0] npc);
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        check("wait_valid_low", 32'(bus.valid), 32'd0);
        check("wait_arvalid_low", 32'(bus.arvalid), 32'd0);
        bus.npc = npc;
        bus.npc_valid = 1'b1;
        step();
        bus.npc_valid = 1'b0;
    endtask

    initial begin
        int   cyc;
        int   n0;
        exp_t e;
        bus.ready = 1'b0;
        bus.npc = 32'h0;
        bus.npc_valid = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_rready", 32'(bus.rready), 32'd0);
        check("rst_ins", bus.ins, 32'h0);
        check("rst_err", 32'(bus.fetch_err), 32'd0);
        check("rst_pc", bus.pc, RST_PC);

        // 1: zero-wait first fetch
        rdata_cfg = 32'h0010_0093;
        sb.push_back('{ins: 32'h0010_0093, pc: RST_PC, err: 1'b0});
        rst_n = 1'b1;
        check("t1_araddr", bus.araddr, RST_PC);
        check("t1_arvalid", 32'(bus.arvalid), 32'd1);
        wait_valid(20, RST_PC, cyc);
        check("t1_latency", cyc, 32'd2);
        pop_compare("t1", e);

        // 2: stalled slave
        ar_stall = 3;
        r_stall = 2;
        rdata_cfg = 32'h0020_0113;
        accept_and_npc(32'h8000_0004);
        sb.push_back('{ins: 32'h0020_0113, pc: 32'h8000_0004, err: 1'b0});
        wait_valid(40, 32'h8000_0004, cyc);
        check("t2_latency", cyc, 32'd7);
        pop_compare("t2", e);
        ar_stall = 0;
        r_stall = 0;

        // 3: decoder back-pressure
        n0 = ar_count;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3_hold_valid", 32'(bus.valid), 32'd1);
            check("t3_hold_ins", bus.ins, e.ins);
            check("t3_hold_pc", bus.pc, e.pc);
            check("t3_no_ar", 32'(bus.arvalid), 32'd0);
        end
        check("t3_ar_count", ar_count, n0);
        rdata_cfg = 32'h0030_0193;
        accept_and_npc(32'h8000_0004);
        sb.push_back('{ins: 32'h0030_0193, pc: 32'h8000_0004, err: 1'b0});
        wait_valid(20, 32'h8000_0004, cyc);
        check("t3_latency", cyc, 32'd2);
        check("t3_fetch_addr", last_araddr, 32'h8000_0004);
        pop_compare("t3", e);

        // 4: bus fault, then recovery via same-cycle ready + npc
        rdata_cfg = 32'hDEAD_BEEF;
        rresp_cfg = 2'b10;
        accept_and_npc(32'h8000_0008);
        sb.push_back('{ins: 32'h0, pc: 32'h8000_0008, err: 1'b1});
        wait_valid(20, 32'h8000_0008, cyc);
        pop_compare("t4_fault", e);
        rdata_cfg = 32'h0040_0213;
        rresp_cfg = 2'b00;
        bus.ready = 1'b1;
        bus.npc = 32'h8000_000C;
        bus.npc_valid = 1'b1;
        step();
        bus.ready = 1'b0;
        bus.npc_valid = 1'b0;
        check("t4_direct_arvalid", 32'(bus.arvalid), 32'd1);
        check("t4_direct_araddr", bus.araddr, 32'h8000_000C);
        sb.push_back('{ins: 32'h0040_0213, pc: 32'h8000_000C, err: 1'b0});
        wait_valid(20, 32'h8000_000C, cyc);
        check("t4_latency", cyc, 32'd2);
        pop_compare("t4_good", e);

        // 5: misaligned next PC
        n0 = ar_count;
        accept_and_npc(32'h8000_0006);
        sb.push_back('{ins: 32'h0, pc: 32'h8000_0006, err: 1'b1});
        check("t5_no_arvalid", 32'(bus.arvalid), 32'd0);
        pop_compare("t5", e);
        check("t5_ar_count", ar_count, n0);
        rdata_cfg = 32'h0050_0293;
        accept_and_npc(32'h8000_0010);
        sb.push_back('{ins: 32'h0050_0293, pc: 32'h8000_0010, err: 1'b0});
        wait_valid(20, 32'h8000_0010, cyc);
        pop_compare("t5_next", e);

        // 6: reset while waiting for read data
        r_stall = 5;
        accept_and_npc(32'h8000_0014);
        step();
        check("t6_in_r", 32'(bus.rready), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.valid), 32'd0);
        check("t6_rst_rready", 32'(bus.rready), 32'd0);
        check("t6_rst_ins", bus.ins, 32'h0);
        check("t6_rst_err", 32'(bus.fetch_err), 32'd0);
        check("t6_rst_pc", bus.pc, RST_PC);
        r_stall = 0;
        rdata_cfg = 32'h0060_0313;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        late_rvalid = 1'b1;
        check("t6_araddr", bus.araddr, RST_PC);
        check("t6_arvalid", 32'(bus.arvalid), 32'd1);
        step();
        late_rvalid = 1'b0;
        check("t6_late_ignored", 32'(bus.valid), 32'd0);
        check("t6_rready", 32'(bus.rready), 32'd1);
        sb.push_back('{ins: 32'h0060_0313, pc: RST_PC, err: 1'b0});
        wait_valid(20, RST_PC, cyc);
        check("t6_latency", cyc, 32'd1);
        pop_compare("t6", e);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
